// File: rtl/ev22_isa_pkg.sv
// EV22 instruction set: mnemonic codes, opcode bases, FSM states and word geometry
// shared by the program encoder and its field packer.
package ev22_isa_pkg;

  localparam int OPC_W  = 8;
  localparam int FLD_W  = 5;
  localparam int WORD_W = OPC_W + 2 * FLD_W;

  typedef enum logic [4:0] {
    M_JMP   = 5'd0,  M_JZE   = 5'd1,  M_JNE   = 5'd2,  M_JCY   = 5'd3,
    M_MOMMW = 5'd4,  M_MOMWM = 5'd5,  M_ADW   = 5'd6,  M_BSR   = 5'd7,
    M_MOVRR = 5'd8,  M_MOVRW = 5'd9,  M_MOKL  = 5'd10, M_MOKWK = 5'd11,
    M_ANK   = 5'd12, M_ORK   = 5'd13, M_ADK   = 5'd14, M_MOVWR = 5'd15,
    M_ANR   = 5'd16, M_ORR   = 5'd17, M_ADR   = 5'd18, M_CPL   = 5'd19,
    M_CLR   = 5'd20, M_SET   = 5'd21, M_RET   = 5'd22, M_LDK16 = 5'd23
  } mnem_e;

  localparam logic [7:0] OPC_JMP   = 8'b0010_0000;
  localparam logic [7:0] OPC_JZE   = 8'b0010_1000;
  localparam logic [7:0] OPC_JNE   = 8'b0011_0000;
  localparam logic [7:0] OPC_JCY   = 8'b0011_1000;
  localparam logic [7:0] OPC_MOMMW = 8'b0001_0000;
  localparam logic [7:0] OPC_MOMWM = 8'b0001_0100;
  localparam logic [7:0] OPC_ADW   = 8'b0001_1000;
  localparam logic [7:0] OPC_BSR   = 8'b0001_1100;
  localparam logic [7:0] OPC_MOVRR = 8'b0000_1000;
  localparam logic [7:0] OPC_MOVRW = 8'b0000_1100;
  localparam logic [7:0] OPC_MOKL  = 8'b0000_0100;
  localparam logic [7:0] OPC_MOKWK = 8'b0100_0100;
  localparam logic [7:0] OPC_ANK   = 8'b0000_0101;
  localparam logic [7:0] OPC_ORK   = 8'b0000_0110;
  localparam logic [7:0] OPC_ADK   = 8'b0000_0111;
  localparam logic [7:0] OPC_MOVWR = 8'b0000_0010;
  localparam logic [7:0] OPC_ANR   = 8'b0100_0010;
  localparam logic [7:0] OPC_ORR   = 8'b0000_0011;
  localparam logic [7:0] OPC_ADR   = 8'b0100_0011;
  localparam logic [7:0] OPC_CPL   = 8'b0000_0000;
  localparam logic [7:0] OPC_CLR   = 8'b0100_0000;
  localparam logic [7:0] OPC_SET   = 8'b0000_0001;
  localparam logic [7:0] OPC_RET   = 8'b0100_0001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EXP  = 2'd2,
    ST_FULL = 2'd3
  } enc_state_e;

  // LDK16 reuses the MOKL base for its low word; its high word uses MOKWK.
  function automatic logic [7:0] base_opcode(input logic [4:0] m);
    logic [7:0] opc;
    case (m)
      M_JMP:   opc = OPC_JMP;
      M_JZE:   opc = OPC_JZE;
      M_JNE:   opc = OPC_JNE;
      M_JCY:   opc = OPC_JCY;
      M_MOMMW: opc = OPC_MOMMW;
      M_MOMWM: opc = OPC_MOMWM;
      M_ADW:   opc = OPC_ADW;
      M_BSR:   opc = OPC_BSR;
      M_MOVRR: opc = OPC_MOVRR;
      M_MOVRW: opc = OPC_MOVRW;
      M_MOKL:  opc = OPC_MOKL;
      M_MOKWK: opc = OPC_MOKWK;
      M_ANK:   opc = OPC_ANK;
      M_ORK:   opc = OPC_ORK;
      M_ADK:   opc = OPC_ADK;
      M_MOVWR: opc = OPC_MOVWR;
      M_ANR:   opc = OPC_ANR;
      M_ORR:   opc = OPC_ORR;
      M_ADR:   opc = OPC_ADR;
      M_CPL:   opc = OPC_CPL;
      M_CLR:   opc = OPC_CLR;
      M_SET:   opc = OPC_SET;
      M_RET:   opc = OPC_RET;
      M_LDK16: opc = OPC_MOKL;
      default: opc = 8'h00;
    endcase
    return opc;
  endfunction

endpackage

// File: rtl/ev22_insn_pack.sv
// Combinational field packer: one symbolic instruction in, one 18-bit program
// word out, plus legality and whether the mnemonic expands to a second word.
module ev22_insn_pack
  import ev22_isa_pkg::*;
(
  input  logic [4:0]        i_mnem,
  input  logic [4:0]        i_ra,
  input  logic [4:0]        i_rb,
  input  logic [15:0]       i_imm,
  input  logic [12:0]       i_addr,
  output logic [WORD_W-1:0] o_word,
  output logic              o_legal,
  output logic              o_two_word
);

  logic [7:0] w_base;

  always_comb begin
    w_base     = base_opcode(i_mnem);
    o_word     = '0;
    o_legal    = 1'b1;
    o_two_word = 1'b0;
    case (i_mnem)
      M_JMP, M_JZE, M_JNE, M_JCY:
        o_word = {w_base | {5'd0, i_addr[12:10]}, i_addr[9:5], i_addr[4:0]};
      // Register-pair ops carry a 2-bit variant suffix taken from Ri's top bits.
      M_MOMMW, M_MOMWM, M_ADW, M_BSR, M_MOVRR, M_MOVRW:
        o_word = {w_base | {6'd0, i_ra[4:3]}, i_ra, i_rb};
      M_MOKL, M_MOKWK, M_ANK, M_ORK, M_ADK:
        o_word = {w_base, 2'b00, i_imm[7:0]};
      M_LDK16: begin
        o_word     = {w_base, 2'b00, i_imm[7:0]};
        o_two_word = 1'b1;
      end
      M_MOVWR, M_ANR, M_ORR, M_ADR:
        o_word = {w_base, i_ra, i_rb};
      M_CPL, M_CLR, M_SET, M_RET:
        o_word = {w_base, 10'd0};
      default:
        o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/prog_encoder.sv
// EV22 program loader: accepts symbolic instructions on a valid/ready port and
// writes encoded words to consecutive program memory addresses.
module prog_encoder
  import ev22_isa_pkg::*;
#(
  parameter int AW = 10,
  parameter int WW = 18
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_mnem,
  input  logic [4:0]    in_ra,
  input  logic [4:0]    in_rb,
  input  logic [15:0]   in_imm,
  input  logic [12:0]   in_addr,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [WW-1:0] mem_wdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          err_illegal,
  output logic          err_overflow,
  output enc_state_e    dbg_state
);

  // Handshake: an instruction transfers on a rising edge where in_valid and
  // in_ready are both high and start is low; start always wins.

  localparam logic [AW:0] CAP  = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] LAST = CAP - 1'b1;

  enc_state_e    r_state, w_next;
  logic [AW-1:0] r_ptr;
  logic [AW:0]   r_count;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [WW-1:0] r_mem_wdata;
  logic          r_err_illegal;
  logic          r_err_overflow;
  logic [7:0]    r_hi_byte;

  logic [WORD_W-1:0] w_word;
  logic              w_legal;
  logic              w_two;
  logic              w_xfer;
  logic              w_full;
  logic              w_one_free;

  ev22_insn_pack u_pack (
    .i_mnem     (in_mnem),
    .i_ra       (in_ra),
    .i_rb       (in_rb),
    .i_imm      (in_imm),
    .i_addr     (in_addr),
    .o_word     (w_word),
    .o_legal    (w_legal),
    .o_two_word (w_two)
  );

  assign w_full     = (r_count == CAP);
  assign w_one_free = (r_count == LAST);
  assign w_xfer     = in_valid && in_ready && !start;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (start) begin
      w_next = ST_LOAD;
    end else begin
      case (r_state)
        ST_LOAD:
          if (w_xfer && w_legal) begin
            if (w_two && !w_one_free) w_next = ST_EXP;
            else if (!w_two && w_one_free) w_next = ST_FULL;
          end
        // r_count here already includes the low word of the LDK16 pair.
        ST_EXP:  w_next = w_one_free ? ST_FULL : ST_LOAD;
        default: w_next = r_state;
      endcase
    end
  end

  always_comb begin
    in_ready  = (r_state == ST_LOAD) && !w_full;
    dbg_state = r_state;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr          <= '0;
      r_count        <= '0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_err_illegal  <= 1'b0;
      r_err_overflow <= 1'b0;
      r_hi_byte      <= '0;
    end else begin
      r_mem_we      <= 1'b0;
      r_err_illegal <= 1'b0;
      if (start) begin
        r_ptr          <= base_addr;
        r_count        <= '0;
        r_err_overflow <= 1'b0;
      end else if (w_xfer) begin
        if (!w_legal) begin
          r_err_illegal <= 1'b1;
        end else if (w_two && w_one_free) begin
          r_err_overflow <= 1'b1;
        end else begin
          r_mem_we    <= 1'b1;
          r_mem_addr  <= r_ptr;
          r_mem_wdata <= w_word;
          r_ptr       <= r_ptr + 1'b1;
          r_count     <= r_count + 1'b1;
          r_hi_byte   <= in_imm[15:8];
        end
      end else if (r_state == ST_EXP) begin
        r_mem_we    <= 1'b1;
        r_mem_addr  <= r_ptr;
        r_mem_wdata <= {OPC_MOKWK, 2'b00, r_hi_byte};
        r_ptr       <= r_ptr + 1'b1;
        r_count     <= r_count + 1'b1;
      end else if (in_valid && r_state == ST_FULL) begin
        r_err_overflow <= 1'b1;
      end
    end
  end

  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign count        = r_count;
  assign full         = w_full;
  assign err_illegal  = r_err_illegal;
  assign err_overflow = r_err_overflow;

endmodule

// File: tb/tb_prog_encoder.sv
// Self-checking bench for prog_encoder at AW=4: directed steps plus random
// instruction streams checked against an arithmetic encoding model.
module tb_prog_encoder;
  import ev22_isa_pkg::*;

  localparam int AW  = 4;
  localparam int WW  = 18;
  localparam int CAP = 16;
  localparam int QW  = AW + WW;

  localparam logic [7:0] OPC_TAB [0:22] = '{
    8'h20, 8'h28, 8'h30, 8'h38, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h08, 8'h0C,
    8'h04, 8'h44, 8'h05, 8'h06, 8'h07, 8'h02, 8'h42, 8'h03, 8'h43,
    8'h00, 8'h40, 8'h01, 8'h41};

  logic          clk = 1'b0;
  logic          rst_n, start, in_valid, in_ready;
  logic [AW-1:0] base_addr;
  logic [4:0]    in_mnem, in_ra, in_rb;
  logic [15:0]   in_imm;
  logic [12:0]   in_addr;
  logic          mem_we, full, err_illegal, err_overflow;
  logic [AW-1:0] mem_addr;
  logic [WW-1:0] mem_wdata;
  logic [AW:0]   count;
  enc_state_e    dbg_state;

  int n_asserts = 0;
  int n_fail    = 0;
  int m_ptr, m_count;
  bit m_ovf;
  logic [QW-1:0] exp_q[$];

  prog_encoder #(.AW(AW), .WW(WW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem),
    .in_ra(in_ra), .in_rb(in_rb), .in_imm(in_imm), .in_addr(in_addr),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .count(count), .full(full), .err_illegal(err_illegal),
    .err_overflow(err_overflow), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference encoding from the instruction-set rules, using plain arithmetic.
  function automatic logic [WW-1:0] ref_word(input int m, input int ra, input int rb,
                                            input int imm, input int ad);
    int op, f1, f2;
    op = OPC_TAB[m];
    f1 = 0;
    f2 = 0;
    if (m <= 3) begin
      op = op + ad / 1024; f1 = (ad / 32) % 32; f2 = ad % 32;
    end else if (m <= 9) begin
      op = op + ra / 8; f1 = ra; f2 = rb;
    end else if (m <= 14) begin
      f1 = (imm % 256) / 32; f2 = imm % 32;
    end else if (m <= 18) begin
      f1 = ra; f2 = rb;
    end
    return {op[7:0], f1[4:0], f2[4:0]};
  endfunction

  task automatic push(input int addr, input logic [WW-1:0] w);
    logic [AW-1:0] a;
    int wrapped;
    wrapped = addr % CAP;
    a = wrapped[AW-1:0];
    exp_q.push_back({a, w});
  endtask

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      n_asserts++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL write_unexpected: observed addr %0h data %0h, expected no write", mem_addr, mem_wdata);
      end
      if (exp_q.size() != 0) chk("mem_write", {mem_addr, mem_wdata}, exp_q.pop_front());
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] b);
    @(negedge clk);
    start = 1'b1;
    base_addr = b;
    tick();
    start = 1'b0;
    m_ptr = b;
    m_count = 0;
    m_ovf = 0;
    chk("start_count", count, 0);
    chk("start_ovf", err_overflow, 0);
    chk("start_full", full, 0);
    chk("start_ready", in_ready, 1);
    chk("start_state", dbg_state, ST_LOAD);
  endtask

  task automatic issue(input logic [4:0] m, input logic [4:0] ra, input logic [4:0] rb,
                       input logic [15:0] imm, input logic [12:0] ad);
    int n, exp_cnt;
    bit exp_ill;
    @(negedge clk);
    in_mnem = m; in_ra = ra; in_rb = rb; in_imm = imm; in_addr = ad;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", in_ready, 1);
    tick();
    in_valid = 1'b0;
    exp_ill = (m >= 24);
    exp_cnt = m_count;
    if (!exp_ill && m == 23) begin
      if (m_count == CAP - 1) begin
        m_ovf = 1;
      end else begin
        push(m_ptr, {8'h04, 2'b00, imm[7:0]});
        push(m_ptr + 1, {8'h44, 2'b00, imm[15:8]});
        m_ptr += 2;
        m_count += 2;
        exp_cnt = m_count - 1;
      end
    end else if (!exp_ill) begin
      push(m_ptr, ref_word(m, ra, rb, imm, ad));
      m_ptr++;
      m_count++;
      exp_cnt = m_count;
    end
    chk("err_illegal", err_illegal, exp_ill);
    chk("err_overflow", err_overflow, m_ovf);
    chk("count", count, exp_cnt);
  endtask

  task automatic poke(input logic [4:0] m);
    @(negedge clk);
    in_mnem = m;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int m, iter;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; base_addr = '0;
    in_mnem = '0; in_ra = '0; in_rb = '0; in_imm = '0; in_addr = '0;
    m_ptr = 0; m_count = 0; m_ovf = 0;
    tick(); tick();
    chk("rst_ready", in_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_full", full, 0);
    chk("rst_ill", err_illegal, 0);
    chk("rst_ovf", err_overflow, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_count", count, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;

    poke(5'd8);
    chk("idle_ignore_ovf", err_overflow, 0);
    chk("idle_state", dbg_state, ST_IDLE);

    // LDK16 expands into two consecutive writes.
    do_start(4'hA);
    issue(5'd23, 5'd0, 5'd0, 16'hBEEF, 13'd0);
    chk("ldk_w1_we", mem_we, 1);
    chk("ldk_w1_addr", mem_addr, 4'hA);
    chk("ldk_w1_data", mem_wdata, {8'h04, 10'h0EF});
    chk("ldk_exp_ready", in_ready, 0);
    tick();
    chk("ldk_w2_we", mem_we, 1);
    chk("ldk_w2_addr", mem_addr, 4'hB);
    chk("ldk_w2_data", mem_wdata, {8'h44, 10'h0BE});
    chk("ldk_ready_back", in_ready, 1);
    chk("ldk_count", count, 2);

    issue(5'd0, 5'd0, 5'd0, 16'd0, 13'h1ABC);
    chk("jmp_data", mem_wdata, {8'h26, 5'h15, 5'h1C});
    chk("jmp_addr", mem_addr, 4'hC);
    issue(5'd6, 5'h1B, 5'h05, 16'd0, 13'd0);
    chk("adw_data", mem_wdata, {8'h1B, 5'h1B, 5'h05});

    // Random streams until full; random base exercises address wrap.
    for (int r = 0; r < 3; r++) begin
      do_start(4'($urandom_range(0, 15)));
      iter = 0;
      while (m_count < CAP && iter < 200) begin
        m = $urandom_range(0, 27);
        if (m > 23) m = $urandom_range(24, 31);
        issue(5'(m), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
              16'($urandom_range(0, 65535)), 13'($urandom_range(0, 8191)));
        iter++;
      end
      tick(); tick();
      chk("rnd_full", full, 1);
      chk("rnd_ready", in_ready, 0);
      chk("rnd_state", dbg_state, ST_FULL);
      chk("rnd_count", count, CAP);
    end

    // Sixteen back-to-back writes fill memory; the next offer overflows.
    do_start(4'h0);
    for (int i = 0; i < CAP; i++) issue(5'd8, 5'(i), 5'(31 - i), 16'd0, 13'd0);
    chk("fill_full", full, 1);
    chk("fill_ready", in_ready, 0);
    chk("fill_state", dbg_state, ST_FULL);
    poke(5'd8);
    chk("fill_ovf", err_overflow, 1);
    chk("fill_no_we", mem_we, 0);
    chk("fill_count", count, CAP);
    do_start(4'h3);

    // One free word: LDK16 refused, then an illegal mnemonic.
    for (int i = 0; i < CAP - 1; i++) issue(5'd15, 5'(i), 5'(i), 16'd0, 13'd0);
    issue(5'd23, 5'd0, 5'd0, 16'h1234, 13'd0);
    chk("ldk1_no_we", mem_we, 0);
    chk("ldk1_state", dbg_state, ST_LOAD);
    issue(5'd25, 5'd0, 5'd0, 16'd0, 13'd0);
    chk("ill_no_we", mem_we, 0);
    tick();
    chk("ill_pulse_end", err_illegal, 0);
    chk("ill_count", count, CAP - 1);

    // Reset during the LDK16 expansion cycle drops the second word.
    do_start(4'h5);
    @(negedge clk);
    in_mnem = 5'd23; in_imm = 16'hCAFE; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    push(5, {8'h04, 2'b00, 8'hFE});
    chk("rexp_state", dbg_state, ST_EXP);
    @(negedge clk);
    rst_n = 1'b0;
    tick();
    chk("rexp_we", mem_we, 0);
    chk("rexp_addr", mem_addr, 0);
    chk("rexp_wdata", mem_wdata, 0);
    chk("rexp_count", count, 0);
    chk("rexp_ready", in_ready, 0);
    chk("rexp_full", full, 0);
    chk("rexp_flags", {err_illegal, err_overflow}, 0);
    chk("rexp_state", dbg_state, ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    tick(); tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_encoder.md
Name: prog_encoder

Overview:
- Program loader and instruction encoder for the EV22 core. It is the write-side counterpart of the instruction decoder.
- It accepts symbolic instructions over a valid/ready handshake and encodes each one into an 18-bit program word {opcode[7:0], f1[4:0], f2[4:0]}.
- It writes the words into program memory at consecutive addresses.
- The 16-bit constant pseudo-instruction LDK16 expands into two words.

Parameters:
- AW, 10, program memory address width; capacity is 2^AW words.
- WW, 18, program word width; fixed 8+5+5.

Ports:
- clk input 1: system clock, rising edge.
- rst_n input 1: reset. Synchronous, active-low.
- start input 1: single-cycle pulse; loads the write pointer from base_addr and clears count and all flags.
- base_addr input AW: first write address.
- in_valid input 1: instruction offered.
- in_ready output 1: encoder can accept an instruction this cycle.
- in_mnem input 5: mnemonic code (see package).
- in_ra input 5: Ri / destination field.
- in_rb input 5: Rj / source field.
- in_imm input 16: immediate K; only [7:0] is used except by LDK16.
- in_addr input 13: jump target.
- mem_we output 1: program memory write strobe.
- mem_addr output AW: write address.
- mem_wdata output WW: encoded word.
- count output AW+1: number of words written since start.
- full output 1: pointer has reached 2^AW words written.
- err_illegal output 1: one-cycle pulse on an undefined mnemonic.
- err_overflow output 1: sticky; an instruction was refused for lack of space. Cleared by start.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - in_ready, mem_we, full, err_illegal, err_overflow are 0.
  - mem_addr, mem_wdata, count are 0.
- Reset takes priority over every other event, including a pending second LDK16 word; that word is discarded.
- States:
  - IDLE: in_ready=0. start goes to LOAD.
  - LOAD: in_ready=1 unless full.
  - EXP: in_ready=0; writes the second LDK16 word.
  - FULL: in_ready=0.
- start has priority over in_valid in every state. It applies in the same cycle: pointer=base_addr, count=0, flags cleared, next state=LOAD.
- Transfer occurs when in_valid && in_ready.
- Write timing is registered: the word appears on mem_we/mem_addr/mem_wdata in the cycle after the transfer, with mem_we high for exactly one cycle. The pointer and count then increment by 1.
- Pointer arithmetic is modulo 2^AW and wraps from all-ones to 0.
- full asserts when count reaches 2^AW. LOAD then goes to FULL, and further in_valid is ignored and sets err_overflow.
- LDK16 needs 2 free words:
  - If exactly 1 word is free, there is no write, err_overflow=1, and the state is unchanged.
  - Otherwise: word 1 is {00000100, 00,in_imm[7:0]}; next cycle (EXP) word 2 is {01000100, 00,in_imm[15:8]}. Then back to LOAD, or FULL if full.
  - Total latency is 2 write cycles, and in_ready is low for 1 cycle.
- Illegal mnemonic (code ≥24): transfer is accepted, there is no write, err_illegal pulses 1 cycle, and the pointer is unchanged.
- Field packing:
  - Jumps: opcode[2:0]=in_addr[12:10], f1=in_addr[9:5], f2=in_addr[4:0].
  - 2-bit opcode suffix (yy/ii/ss) = in_ra[4:3]. f1=in_ra, f2=in_rb.
  - K-ops: {f1[2:0],f2}=in_imm[7:0], f1[4:3]=0.
  - No-operand ops: f1=f2=0.

Decomposition:
- Package ev22_isa_pkg holds:
  - The mnemonic enum: JMP0 JZE1 JNE2 JCY3 MOMMW4 MOMWM5 ADW6 BSR7 MOVRR8 MOVRW9 MOKL10 MOKWK11 ANK12 ORK13 ADK14 MOVWR15 ANR16 ORR17 ADR18 CPL19 CLR20 SET21 RET22 LDK16_23.
  - Opcode base constants: JMP 00100000, JZE 00101000, JNE 00110000, JCY 00111000, MOMMW 00010000, MOMWM 00010100, ADW 00011000, BSR 00011100, MOVRR 00001000, MOVRW 00001100, MOKL 00000100, MOKWK 01000100, ANK 00000101, ORK 00000110, ADK 00000111, MOVWR 00000010, ANR 01000010, ORR 00000011, ADR 01000011, CPL 00000000, CLR 01000000, SET 00000001, RET 01000001.
  - Word-width constants.
- Sub-module ev22_insn_pack is purely combinational: mnemonic + fields gives {word, legal, two_word}. The FSM, pointer and flags stay in prog_encoder.

Test Plan:
- start with base_addr=0x010, then LDK16 in_imm=0xBEEF → mem writes at 0x010 = {00000100,0x00EF} and 0x011 = {01000100,0x00BE} on consecutive cycles; in_ready low 1 cycle; count=2.
- JMP in_addr=0x1ABC → mem_wdata = {00100110, f1=0x15, f2=0x1C}; pointer +1.
- ADW in_ra=0x1B, in_rb=0x05 → opcode 00011011, f1=0x1B, f2=0x05.
- AW=4: 16 back-to-back MOVRR → full=1 after the 16th write, in_ready=0; the 17th in_valid gives no write and err_overflow=1; start clears it.
- AW=4 with 15 words written, then LDK16 → no write, err_overflow=1, count stays 15. in_mnem=25 gives an err_illegal 1-cycle pulse and no mem_we.
- rst_n low in the EXP cycle of LDK16 → the second word is not written, all outputs 0 the next cycle, state IDLE.
